// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of the two requester ports and the single-port
//                memory bus handled by mem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int WORD_SIZE    = 10,
    parameter int ADDRESS_SIZE = 8
);
    // Requester side
    logic                    req0;
    logic                    req1;
    logic                    we0;
    logic                    we1;
    logic [ADDRESS_SIZE-1:0] addr0;
    logic [ADDRESS_SIZE-1:0] addr1;
    logic [WORD_SIZE-1:0]    wdata0;
    logic [WORD_SIZE-1:0]    wdata1;
    logic                    gnt0;
    logic                    gnt1;
    logic                    done0;
    logic                    done1;
    logic [WORD_SIZE-1:0]    rdata0;
    logic [WORD_SIZE-1:0]    rdata1;
    logic                    busy;

    // Memory side
    logic [ADDRESS_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0]    mem_din;
    logic                    mem_we;
    logic [WORD_SIZE-1:0]    mem_dout;

    // Arbiter view
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        output gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
               mem_addr, mem_din, mem_we
    );

    // Requester / memory environment view
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
               mem_addr, mem_din, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter and access sequencer letting the CPU
//                data path (port 0) and program loader (port 1) share one
//                single-port memory. One access every 3 cycles at most.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int WORD_SIZE    = 10,
    parameter int ADDRESS_SIZE = 8
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_accept;
    logic                    w_winner;
    logic                    w_sel_we;
    logic [ADDRESS_SIZE-1:0] w_sel_addr;
    logic [WORD_SIZE-1:0]    w_sel_wdata;

    logic                    r_owner;
    logic                    r_prio;
    logic                    r_is_write;
    logic                    r_gnt0;
    logic                    r_gnt1;
    logic                    r_done0;
    logic                    r_done1;
    logic                    r_mem_we;
    logic [ADDRESS_SIZE-1:0] r_mem_addr;
    logic [WORD_SIZE-1:0]    r_mem_din;
    logic [WORD_SIZE-1:0]    r_rdata0;
    logic [WORD_SIZE-1:0]    r_rdata1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; arbitration happens only in IDLE or DONE, so requests are
    // ignored while an access is in flight
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        // A lone requester always wins; under contention the pointer decides
        w_winner     = (bus.req0 && bus.req1) ? r_prio : bus.req1;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.req0 || bus.req1) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_ISSUE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ISSUE:   w_state_next = ST_CAPTURE;
            ST_CAPTURE: w_state_next = ST_DONE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Winner's request fields
    always_comb begin
        w_sel_we    = w_winner ? bus.we1    : bus.we0;
        w_sel_addr  = w_winner ? bus.addr1  : bus.addr0;
        w_sel_wdata = w_winner ? bus.wdata1 : bus.wdata0;
    end

    // Transaction registers, pulses and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= 1'b0;
            r_prio     <= 1'b0;
            r_is_write <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_gnt0   <= w_accept && !w_winner;
            r_gnt1   <= w_accept &&  w_winner;
            r_done0  <= (r_state == ST_CAPTURE) && !r_owner;
            r_done1  <= (r_state == ST_CAPTURE) &&  r_owner;
            // Write strobe lives only in ISSUE; address/data keep their value
            r_mem_we <= w_accept && w_sel_we;
            if (w_accept) begin
                r_owner    <= w_winner;
                r_prio     <= ~w_winner;
                r_is_write <= w_sel_we;
                r_mem_addr <= w_sel_addr;
                r_mem_din  <= w_sel_wdata;
            end
            // Memory output is valid in CAPTURE, one cycle after ISSUE
            if ((r_state == ST_CAPTURE) && !r_is_write) begin
                if (r_owner) begin
                    r_rdata1 <= bus.mem_dout;
                end else begin
                    r_rdata0 <= bus.mem_dout;
                end
            end
        end
    end

    assign bus.gnt0     = r_gnt0;
    assign bus.gnt1     = r_gnt1;
    assign bus.done0    = r_done0;
    assign bus.done1    = r_done1;
    assign bus.rdata0   = r_rdata0;
    assign bus.rdata1   = r_rdata1;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
    assign bus.mem_we   = r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter with a behavioural
//                single-port memory and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int WS = 10;
    localparam int AS = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mem_arbiter_if #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS)) bus ();

    mem_arbiter #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory_Unit model: synchronous write, registered read data
    bit [WS-1:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= mem[bus.mem_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          port;
        bit          we;
        logic [7:0]  addr;
        logic [9:0]  wdata;
        logic [9:0]  exp_rd0;
        logic [9:0]  exp_rd1;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_port(input bit p, input bit r, input bit w,
                            input logic [7:0] a, input logic [9:0] d);
        if (p) begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    function automatic logic gnt_of(input bit p);
        return p ? bus.gnt1 : bus.gnt0;
    endfunction

    function automatic logic done_of(input bit p);
        return p ? bus.done1 : bus.done0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        set_port(0, 0, 0, 8'h00, 10'h000);
        set_port(1, 0, 0, 8'h00, 10'h000);
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_gnt",      {bus.gnt1, bus.gnt0},   0);
        chk("rst_done",     {bus.done1, bus.done0}, 0);
        chk("rst_mem_we",   bus.mem_we,   0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_din",  bus.mem_din,  0);
        chk("rst_rdata0",   bus.rdata0,   0);
        chk("rst_rdata1",   bus.rdata1,   0);
        reset = 1'b0;
    endtask

    // One isolated access starting from IDLE, checked cycle by cycle
    task automatic txn(input bit p, input bit w, input logic [7:0] a, input logic [9:0] d,
                       input logic [9:0] e0, input logic [9:0] e1);
        set_port(p, 1, w, a, d);
        @(negedge clk);
        chk("txn_gnt",       gnt_of(p),  1);
        chk("txn_gnt_other", gnt_of(!p), 0);
        chk("txn_we_issue",  bus.mem_we, w);
        chk("txn_addr",      bus.mem_addr, a);
        if (w) chk("txn_din", bus.mem_din, d);
        chk("txn_busy",      bus.busy, 1);
        @(negedge clk);
        chk("txn_we_capture", bus.mem_we, 0);
        chk("txn_gnt_pulse",  gnt_of(p), 0);
        chk("txn_done_early", done_of(p), 0);
        @(negedge clk);
        chk("txn_done",   done_of(p), 1);
        chk("txn_rdata0", bus.rdata0, e0);
        chk("txn_rdata1", bus.rdata1, e1);
        set_port(p, 0, 0, a, d);
        @(negedge clk);
        chk("txn_done_pulse", done_of(p), 0);
        chk("txn_idle",       bus.busy, 0);
    endtask

    // Randomised traffic on both ports against a transaction-level model
    task automatic run_random(input int ncyc);
        bit          ptr;
        bit          ov;
        int          og;
        bit          oport;
        bit          owe;
        logic [7:0]  oaddr;
        logic [9:0]  oval;
        logic [9:0]  erd [2];
        bit [9:0]    rmem [0:255];
        bit          rq [2];
        bit          fly [2];
        bit          w [2];
        logic [7:0]  a [2];
        logic [9:0]  d [2];
        bit          eg [2];
        bit          ed [2];
        bit          win;
        ptr = 0; ov = 0; og = -10; oport = 0; owe = 0; oaddr = 0; oval = 0;
        erd[0] = 0; erd[1] = 0;
        rmem = mem;
        for (int x = 0; x < 2; x++) begin
            rq[x] = 0; fly[x] = 0; w[x] = 0; a[x] = 0; d[x] = 0;
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int x = 0; x < 2; x++) begin
                eg[x] = ov && (og == c)     && (oport == 1'(x));
                ed[x] = ov && (og + 2 == c) && (oport == 1'(x));
            end
            if (ov && (og + 2 == c) && !owe) erd[oport] = oval;
            chk("rnd_gnt0",  bus.gnt0,  eg[0]);
            chk("rnd_gnt1",  bus.gnt1,  eg[1]);
            chk("rnd_done0", bus.done0, ed[0]);
            chk("rnd_done1", bus.done1, ed[1]);
            chk("rnd_mem_we", bus.mem_we, ov && (og == c) && owe);
            chk("rnd_busy",  bus.busy,  ov && (c >= og) && (c <= og + 2));
            chk("rnd_rdata0", bus.rdata0, erd[0]);
            chk("rnd_rdata1", bus.rdata1, erd[1]);
            if (eg[0] || eg[1]) chk("rnd_mem_addr", bus.mem_addr, oaddr);
            // Requester agents
            for (int x = 0; x < 2; x++) begin
                if (ed[x]) begin
                    fly[x] = 0;
                    rq[x]  = 1'($urandom_range(0, 1));
                end else if (eg[x]) begin
                    fly[x] = 1;
                    if ($urandom_range(0, 3) == 0) rq[x] = 0;
                end else if (!fly[x] && !rq[x] && $urandom_range(0, 2) == 0) begin
                    rq[x] = 1;
                end
                if (rq[x] && !fly[x]) begin
                    if (ed[x] || !(eg[x])) begin
                        w[x] = 1'($urandom_range(0, 1));
                        a[x] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
                        d[x] = 10'($urandom);
                    end
                end
                set_port(1'(x), rq[x], w[x], a[x], d[x]);
            end
            // Model: the memory serves whole accesses in grant order
            if ((!ov || c >= og + 2) && (rq[0] || rq[1])) begin
                win   = (rq[0] && rq[1]) ? ptr : rq[1];
                ptr   = ~win;
                ov    = 1;
                og    = c + 1;
                oport = win;
                owe   = w[win];
                oaddr = a[win];
                if (owe) rmem[a[win]] = d[win];
                else     oval = rmem[a[win]];
            end
        end
        set_port(0, 0, 0, 8'h00, 10'h000);
        set_port(1, 0, 0, 8'h00, 10'h000);
        repeat (4) @(negedge clk);
        chk("rnd_final_idle", bus.busy, 0);
    endtask

    initial begin
        vec_t vecs [10];
        int   ng;
        int   last;
        bit   seen_end;

        vecs[0] = '{0, 1, 8'h05, 10'h2AA, 10'h000, 10'h000};
        vecs[1] = '{0, 0, 8'h05, 10'h000, 10'h2AA, 10'h000};
        vecs[2] = '{0, 1, 8'h20, 10'h155, 10'h2AA, 10'h000};
        vecs[3] = '{0, 0, 8'h20, 10'h000, 10'h155, 10'h000};
        vecs[4] = '{0, 1, 8'h21, 10'h3FF, 10'h155, 10'h000};
        vecs[5] = '{1, 0, 8'h21, 10'h000, 10'h155, 10'h3FF};
        vecs[6] = '{1, 1, 8'hFF, 10'h001, 10'h155, 10'h3FF};
        vecs[7] = '{1, 0, 8'hFF, 10'h000, 10'h155, 10'h001};
        vecs[8] = '{0, 0, 8'h00, 10'h000, 10'h000, 10'h001};
        vecs[9] = '{1, 0, 8'h05, 10'h000, 10'h000, 10'h2AA};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rd0, vecs[i].exp_rd1);
        end

        // Simultaneous requests after reset: port 0 first, port 1 in DONE
        do_reset();
        set_port(0, 1, 0, 8'h01, 10'h000);
        set_port(1, 1, 1, 8'h03, 10'h120);
        @(negedge clk);
        chk("sim_gnt0", bus.gnt0, 1);
        chk("sim_gnt1_wait", bus.gnt1, 0);
        chk("sim_addr0", bus.mem_addr, 8'h01);
        @(negedge clk);
        chk("sim_mid", {bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 0);
        @(negedge clk);
        chk("sim_done0", bus.done0, 1);
        chk("sim_gnt1_not_yet", bus.gnt1, 0);
        chk("sim_rdata0", bus.rdata0, 10'h000);
        set_port(0, 0, 0, 8'h01, 10'h000);
        @(negedge clk);
        chk("sim_gnt1", bus.gnt1, 1);
        chk("sim_done0_pulse", bus.done0, 0);
        chk("sim_we1", bus.mem_we, 1);
        chk("sim_addr1", bus.mem_addr, 8'h03);
        chk("sim_din1", bus.mem_din, 10'h120);
        @(negedge clk);
        chk("sim_done1_early", bus.done1, 0);
        @(negedge clk);
        chk("sim_done1", bus.done1, 1);
        set_port(1, 0, 0, 8'h03, 10'h120);
        @(negedge clk);
        chk("sim_idle", bus.busy, 0);
        txn(0, 0, 8'h03, 10'h000, 10'h120, 10'h000);

        // Fairness under continuous contention
        do_reset();
        set_port(0, 1, 0, 8'h05, 10'h000);
        set_port(1, 1, 0, 8'hFF, 10'h000);
        ng = 0; last = 0; seen_end = 0;
        for (int c = 1; c <= 40 && !seen_end; c++) begin
            @(negedge clk);
            chk("fair_no_dual_gnt", bus.gnt0 & bus.gnt1, 0);
            if (bus.gnt0 || bus.gnt1) begin
                if (ng < 6) begin
                    chk("fair_order", bus.gnt1, ng % 2);
                    if (ng > 0) chk("fair_spacing", c - last, 3);
                end
                last = c;
                ng++;
            end
            if (ng == 6 && c == last + 2) begin
                set_port(0, 0, 0, 8'h05, 10'h000);
                set_port(1, 0, 0, 8'hFF, 10'h000);
                seen_end = 1;
            end
        end
        chk("fair_six_grants", ng, 6);
        @(negedge clk);
        chk("fair_idle", bus.busy, 0);
        chk("fair_rdata0", bus.rdata0, 10'h2AA);
        chk("fair_rdata1", bus.rdata1, 10'h001);

        // Request withdrawn after grant still completes
        set_port(1, 1, 1, 8'h10, 10'h0FF);
        @(negedge clk);
        chk("wd_gnt1", bus.gnt1, 1);
        @(negedge clk);
        set_port(1, 0, 0, 8'h00, 10'h000);
        @(negedge clk);
        chk("wd_done1", bus.done1, 1);
        @(negedge clk);
        chk("wd_idle", bus.busy, 0);
        txn(0, 0, 8'h10, 10'h000, 10'h0FF, 10'h001);

        // Reset during CAPTURE of a port-0 read; pointer points at port 1 before it
        set_port(0, 1, 0, 8'h05, 10'h000);
        @(negedge clk);
        chk("mrst_gnt0", bus.gnt0, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_busy",   bus.busy,   0);
        chk("mrst_we",     bus.mem_we, 0);
        chk("mrst_done0",  bus.done0,  0);
        chk("mrst_rdata0", bus.rdata0, 0);
        chk("mrst_rdata1", bus.rdata1, 0);
        chk("mrst_addr",   bus.mem_addr, 0);
        reset = 1'b0;
        set_port(0, 0, 0, 8'h00, 10'h000);
        @(negedge clk);
        chk("mrst_no_done0", bus.done0, 0);
        chk("mrst_still_idle", bus.busy, 0);
        set_port(0, 1, 0, 8'h05, 10'h000);
        set_port(1, 1, 0, 8'hFF, 10'h000);
        @(negedge clk);
        chk("mrst_ptr_gnt0", bus.gnt0, 1);
        chk("mrst_ptr_gnt1", bus.gnt1, 0);
        @(negedge clk);
        @(negedge clk);
        chk("mrst_done0_after", bus.done0, 1);
        chk("mrst_rdata0_after", bus.rdata0, 10'h2AA);
        set_port(0, 0, 0, 8'h00, 10'h000);
        @(negedge clk);
        chk("mrst_gnt1_after", bus.gnt1, 1);
        @(negedge clk);
        @(negedge clk);
        chk("mrst_done1_after", bus.done1, 1);
        chk("mrst_rdata1_after", bus.rdata1, 10'h001);
        set_port(1, 0, 0, 8'h00, 10'h000);
        @(negedge clk);

        // Random contention against the reference model
        do_reset();
        run_random(800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
